hazard_forward_ctrl: RTL
========================

// Module: hazard_forward_ctrl
// PURPOSE
//  Hazard/forwarding controller for the 5-stage core; sequences the EX-stage ALU datapath.
//  Keeps a shadow pipeline (EX/MEM/WB) of destination-register info and decodes forwardA/forwardB.
//  Generates load-use stalls, branch-taken flushes and data-memory-wait freezes; counts stall and flush cycles.
// PARAMETERS
//  REG_AW  5   register-address width
//  CNT_W   32  perf-counter width
// PORTS
//  clk             in   1       core clock, all state on rising edge
//  rst_n           in   1       reset, asynchronous, active-low
//  id_valid        in   1       ID stage holds a real instruction
//  id_rs1,id_rs2   in   REG_AW  ID source registers
//  id_use_rs1/rs2  in   1       ID instruction actually reads rs1/rs2
//  id_rd           in   REG_AW  ID destination register
//  id_reg_write    in   1       ID instruction writes rd
//  id_mem_read     in   1       ID instruction is a load
//  ex_branch_taken in   1       EX branch/jump resolved taken (qualified by datapath)
//  dmem_busy       in   1       data memory not ready this cycle
//  forwardA        out  2       rs1 forward select for EX: 00 regfile, 01 MEM/WB, 10 EX/MEM
//  forwardB        out  2       rs2 forward select for EX, same encoding
//  pc_hold         out  1       PC keeps value
//  ifid_hold       out  1       IF/ID register keeps value
//  ifid_flush      out  1       IF/ID loads bubble
//  idex_flush      out  1       ID/EX loads bubble
//  pipe_freeze     out  1       every pipeline register (incl. PC) holds
//  stall_cnt       out  CNT_W   load-use + mem-wait stall cycles since reset
//  flush_cnt       out  CNT_W   taken-branch flushes since reset
// BEHAVIOUR
//  Reset: all shadow valid bits 0, state RUN, counters 0; all outputs 0 / 2'b00 while rst_n low.
//  Shadow regs: ex_{valid,rs1,rs2,use1,use2,rd,rw,mr}, mem_{valid,rd,rw}, wb_{valid,rd,rw}.
//  Advance on edge when !pipe_freeze: wb<=mem; mem<=ex; ex<=ID fields, or bubble (valid=0) if idex_flush.
//  Forwarding (comb from shadow regs only, so stable whole cycle):
//   10 if mem_valid&mem_rw&mem_rd!=0&mem_rd==ex_rsN&ex_useN; else 01 if same with wb; else 00.
//   EX/MEM beats MEM/WB on double match; rd==x0 never forwarded; ex_valid=0 -> 00.
//  load_use = id_valid&ex_valid&ex_mr&ex_rd!=0&((use1&rs1==ex_rd)|(use2&rs2==ex_rd)).
//  taken = ex_valid&ex_branch_taken.
//  Priority (comb): dmem_busy > taken > load_use.
//   dmem_busy: pipe_freeze=1, pc_hold=1, ifid_hold=1, flushes 0; taken re-evaluated after release.
//   taken: ifid_flush=1, idex_flush=1, pc_hold=0 (datapath loads target); load_use ignored.
//   load_use: pc_hold=1, ifid_hold=1, idex_flush=1; exactly one bubble (load then in MEM, no re-match).
//  Load result reaches dependent via MEM/WB path (01). WB->ID bypass is regfile write-first, not here.
//  FSM: RUN -> MEM_WAIT when dmem_busy; MEM_WAIT -> RUN on first !dmem_busy cycle; release cycle
//   is a normal RUN-priority cycle (taken/load_use apply).
//  stall_cnt +1 per cycle with load_use (unfrozen) or pipe_freeze; flush_cnt +1 per unfrozen taken cycle.
//  Counters saturate at all-ones, never wrap.
//  Reset mid-operation: shadow pipeline emptied immediately (async); no stale forward after release.
// STRUCTURE
//  Shared header hazard_defs.vh: FWD_REG=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10, ST_RUN, ST_MEM_WAIT.
//  Sub-module fwd_sel (comb match/priority for one operand), instantiated for A and B.
//  Top: shadow pipeline, priority logic, FSM, saturating counters.
// TESTING
//  add x5 then add x6,x5,x1 back-to-back -> forwardA=10 in dependent's EX cycle, no stall.
//  add x5; nop; sub x7,x1,x5 -> forwardB=01; add x0 producer + x0 consumer -> forwardA=00.
//  lw x5 then add x6,x5,x5 -> 1 cycle pc_hold/ifid_hold/idex_flush, then forwardA=forwardB=01, stall_cnt=1.
//  beq taken with lw-dependent in ID same cycle -> ifid_flush=idex_flush=1, no stall, flush_cnt=1.
//  dmem_busy high 3 cycles while taken branch in EX -> pipe_freeze 3 cycles, stall_cnt+=3, flush on release.
//  rst_n pulsed low mid-stream with producer in MEM -> forwardA/B=00, counters 0; saturation preset at max holds.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl_pkg
//   Shared encodings for the hazard/forwarding controller.
//   - FWD_*   : forward-select encodings driven onto forwardA/forwardB
//   - state_e : controller state (normal issue vs. waiting on data memory)
// -----------------------------------------------------------------------------
package hazard_forward_ctrl_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_MEMWB = 2'b01;  // operand from MEM/WB result
    localparam logic [1:0] FWD_EXMEM = 2'b10;  // operand from EX/MEM result

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_sel.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl_fwd_sel
//   Forward-select decode for one EX-stage source operand.
//   Ports:
//     ex_valid_i  EX shadow holds a real instruction
//     ex_rs_i     EX source register for this operand
//     ex_use_i    EX instruction reads this operand
//     mem_*_i     EX/MEM producer: valid, writes rd, rd
//     wb_*_i      MEM/WB producer: valid, writes rd, rd
//     fwd_o       FWD_EXMEM / FWD_MEMWB / FWD_REG
// -----------------------------------------------------------------------------
module hazard_forward_ctrl_fwd_sel
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid_i,
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic              ex_use_i,
    input  logic              mem_valid_i,
    input  logic              mem_rw_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              wb_valid_i,
    input  logic              wb_rw_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    output logic [1:0]        fwd_o
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired zero, so a producer targeting it never forwards.
    assign mem_hit = mem_valid_i && mem_rw_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i);
    assign wb_hit  = wb_valid_i  && wb_rw_i  && (wb_rd_i  != '0) && (wb_rd_i  == ex_rs_i);

    // The younger producer (EX/MEM) holds the newest value on a double match.
    always_comb begin
        fwd_o = FWD_REG;
        if (ex_valid_i && ex_use_i) begin
            if (mem_hit) begin
                fwd_o = FWD_EXMEM;
            end else if (wb_hit) begin
                fwd_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
//   Hazard / forwarding controller for the 5-stage core.
//   Tracks destination-register info for EX/MEM/WB in a shadow pipeline,
//   decodes forwardA/forwardB, and raises load-use stalls, taken-branch
//   flushes and data-memory freezes. Counts stall and flush cycles.
//   Ports:
//     clk, rst_n                 clock; async active-low reset
//     id_*                       ID-stage instruction info
//     ex_branch_taken            EX branch resolved taken
//     dmem_busy                  data memory not ready
//     forwardA/forwardB          EX operand forward selects
//     pc_hold, ifid_hold         hold PC / IF/ID
//     ifid_flush, idex_flush     bubble into IF/ID / ID/EX
//     pipe_freeze                hold every pipeline register
//     stall_cnt, flush_cnt       saturating performance counters
// -----------------------------------------------------------------------------
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    input  logic              dmem_busy,
    output logic [1:0]        forwardA,
    output logic [1:0]        forwardB,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              pipe_freeze,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int               NUM_OPS = 2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ---------------- shadow pipeline ----------------
    logic                             ex_valid_q, ex_rw_q, ex_mr_q;
    logic [REG_AW-1:0]                ex_rd_q;
    logic [NUM_OPS-1:0][REG_AW-1:0]   ex_rs_q;
    logic [NUM_OPS-1:0]               ex_use_q;
    logic                             mem_valid_q, mem_rw_q;
    logic [REG_AW-1:0]                mem_rd_q;
    logic                             wb_valid_q, wb_rw_q;
    logic [REG_AW-1:0]                wb_rd_q;

    logic [NUM_OPS-1:0][REG_AW-1:0]   id_rs;
    logic [NUM_OPS-1:0]               id_use;
    logic [NUM_OPS-1:0][1:0]          fwd;

    // ---------------- control ----------------
    logic load_use, taken;
    logic pc_hold_c, ifid_hold_c, ifid_flush_c, idex_flush_c, freeze_c;
    logic stall_ev, flush_ev;
    state_e state_q, state_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign id_rs  = {id_rs2, id_rs1};
    assign id_use = {id_use_rs2, id_use_rs1};

    // Forward decode looks only at shadow registers, so the selects are
    // stable for the whole EX cycle regardless of ID-side input timing.
    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        hazard_forward_ctrl_fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
            .ex_valid_i  (ex_valid_q),
            .ex_rs_i     (ex_rs_q[g]),
            .ex_use_i    (ex_use_q[g]),
            .mem_valid_i (mem_valid_q),
            .mem_rw_i    (mem_rw_q),
            .mem_rd_i    (mem_rd_q),
            .wb_valid_i  (wb_valid_q),
            .wb_rw_i     (wb_rw_q),
            .wb_rd_i     (wb_rd_q),
            .fwd_o       (fwd[g])
        );
    end

    assign forwardA = fwd[0];
    assign forwardB = fwd[1];

    assign load_use = id_valid && ex_valid_q && ex_mr_q && (ex_rd_q != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd_q)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd_q)));
    assign taken    = ex_valid_q && ex_branch_taken;

    // Priority: memory wait freezes everything (branch is re-evaluated once
    // memory releases), then taken branch, then load-use. A taken branch
    // squashes the dependent in ID, so its load-use is moot.
    always_comb begin
        pc_hold_c    = 1'b0;
        ifid_hold_c  = 1'b0;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        freeze_c     = 1'b0;
        stall_ev     = 1'b0;
        flush_ev     = 1'b0;
        if (dmem_busy) begin
            freeze_c    = 1'b1;
            pc_hold_c   = 1'b1;
            ifid_hold_c = 1'b1;
            stall_ev    = 1'b1;
        end else if (taken) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            flush_ev     = 1'b1;
        end else if (load_use) begin
            pc_hold_c    = 1'b1;
            ifid_hold_c  = 1'b1;
            idex_flush_c = 1'b1;
            stall_ev     = 1'b1;
        end
    end

    // Control outputs are forced low while reset is asserted.
    assign pc_hold     = rst_n & pc_hold_c;
    assign ifid_hold   = rst_n & ifid_hold_c;
    assign ifid_flush  = rst_n & ifid_flush_c;
    assign idex_flush  = rst_n & idex_flush_c;
    assign pipe_freeze = rst_n & freeze_c;

    // Shadow pipeline advance. A load-use bubble moves the load into MEM,
    // so the held dependent does not re-match on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_rd_q     <= '0;
            ex_rs_q     <= '0;
            ex_use_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_rd_q     <= '0;
        end else if (!freeze_c) begin
            wb_valid_q  <= mem_valid_q;
            wb_rw_q     <= mem_rw_q;
            wb_rd_q     <= mem_rd_q;
            mem_valid_q <= ex_valid_q;
            mem_rw_q    <= ex_rw_q;
            mem_rd_q    <= ex_rd_q;
            ex_rd_q     <= id_rd;
            ex_rs_q     <= id_rs;
            ex_use_q    <= id_use;
            if (idex_flush_c) begin
                ex_valid_q <= 1'b0;
                ex_rw_q    <= 1'b0;
                ex_mr_q    <= 1'b0;
            end else begin
                ex_valid_q <= id_valid;
                ex_rw_q    <= id_reg_write;
                ex_mr_q    <= id_mem_read;
            end
        end
    end

    // ---------------- FSM ----------------
    // Release cycle is handled as an ordinary RUN cycle by the priority logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (dmem_busy)  state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: if (!dmem_busy) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- saturating counters ----------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_ev && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_ev && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
